// File: rtl/my_timer_cpu_debug_mem_ctrl_pkg.sv
// Shared types and constants for the debug-RAM access controller:
// FSM state encoding, jdo field positions and the default abort timeout.
package my_timer_cpu_debug_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int JDO_W    = 38;
  localparam int DATA_W   = 32;
  localparam int ADDR_LSB = 10;
  localparam int DATA_LSB = 3;
  localparam int RD_FLAG  = 34;
  localparam int CLR_ERR  = 35;

  localparam int TIMEOUT_CYC_DEFAULT = 255;

endpackage

// File: rtl/my_timer_cpu_debug_mem_ctrl_if.sv
// Debug-RAM request/acknowledge bus; the controller is the master, the memory the slave.
interface my_timer_cpu_debug_mem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/my_timer_cpu_debug_mem_ctrl.sv
// Turns sysclk-side OCI memory strobes into single debug-RAM accesses with auto-incrementing address.
// Define DEBUG_MEM_TIMEOUT_EN to abort a request that sees no mem_ack within TIMEOUT_CYC cycles.
module my_timer_cpu_debug_mem_ctrl
  import my_timer_cpu_debug_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [JDO_W-1:0]              jdo,
  input  logic                          take_action_ocimem_a,
  input  logic                          take_no_action_ocimem_a,
  input  logic                          take_action_ocimem_b,
  my_timer_cpu_debug_mem_ctrl_if.master mem,
  output logic [DATA_W-1:0]             MonDReg,
  output logic                          monitor_ready,
  output logic                          monitor_error
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   mon_q, mon_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;

  logic any_strobe;
  logic collision;
  logic unused_jdo;

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign collision  = (take_action_ocimem_a & take_action_ocimem_b)
                    | (take_action_ocimem_a & take_no_action_ocimem_a)
                    | (take_action_ocimem_b & take_no_action_ocimem_a);
  assign unused_jdo = ^{jdo[JDO_W-1:CLR_ERR+1], jdo[DATA_LSB-1:0]};

`ifdef DEBUG_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mon_d       = mon_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    err_d       = err_q;
`ifdef DEBUG_MEM_TIMEOUT_EN
    cnt_d       = '0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          addr_d = jdo[ADDR_LSB +: ADDR_W];
          if (jdo[CLR_ERR]) err_d = 1'b0;
          if (jdo[RD_FLAG]) begin
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = jdo[ADDR_LSB +: ADDR_W];
          end
        end else if (take_action_ocimem_b) begin
          state_d     = ST_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = jdo[DATA_LSB +: DATA_W];
        end else if (take_no_action_ocimem_a) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_q;
        end
        // A collision flags an error even when the same ocimem_a asks to clear it.
        if (collision) err_d = 1'b1;
      end

      ST_REQ: begin
        if (any_strobe) err_d = 1'b1;
        if (mem.mem_ack) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          addr_d    = addr_q + 1'b1;
          if (!mem_we_q) mon_d = mem.mem_rdata;
        end
`ifdef DEBUG_MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      ST_DONE: begin
        if (any_strobe) err_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mon_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
`ifdef DEBUG_MEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mon_q       <= mon_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
`ifdef DEBUG_MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_my_timer_cpu_debug_mem_ctrl.sv
// Directed bench: stimulus pushes expected memory requests into a queue; a monitor pops and checks them.
module tb_my_timer_cpu_debug_mem_ctrl;
  import my_timer_cpu_debug_mem_ctrl_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [JDO_W-1:0]  jdo = '0;
  logic              ta = 1'b0;
  logic              tna = 1'b0;
  logic              tbw = 1'b0;
  logic [31:0]       mon;
  logic              ready;
  logic              err;

  my_timer_cpu_debug_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  my_timer_cpu_debug_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta),
    .take_no_action_ocimem_a (tna),
    .take_action_ocimem_b    (tbw),
    .mem                     (bus),
    .MonDReg                 (mon),
    .monitor_ready           (ready),
    .monitor_error           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } txn_t;

  txn_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: each rising mem_req is one transaction checked against the queue head.
  logic              prev_req = 1'b0;
  logic [ADDR_W-1:0] cur_addr = '0;
  txn_t              mon_e;

  always @(negedge clk) begin
    if (bus.mem_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_req: got we=%0d addr=0x%02h expected no request", bus.mem_we, bus.mem_addr);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn we=%0d addr=0x%02h wdata=0x%08h", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        check("req_we", 32'(bus.mem_we), 32'(mon_e.we));
        check("req_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        if (mon_e.we) check("req_wdata", bus.mem_wdata, mon_e.wdata);
      end
      cur_addr = bus.mem_addr;
    end else if (bus.mem_req && prev_req && bus.mem_addr !== cur_addr) begin
      n_vec++;
      n_err++;
      $display("FAIL addr_hold: got 0x%02h expected 0x%02h", bus.mem_addr, cur_addr);
    end
    prev_req = bus.mem_req;
  end

  function automatic logic [JDO_W-1:0] mk_a(input logic [7:0] a, input logic rd, input logic clr);
    logic [JDO_W-1:0] j;
    j = '0;
    j[17:10] = a;
    j[RD_FLAG] = rd;
    j[CLR_ERR] = clr;
    return j;
  endfunction

  function automatic logic [JDO_W-1:0] mk_b(input logic [31:0] d);
    logic [JDO_W-1:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic strobe(input logic a, input logic b, input logic na, input logic [JDO_W-1:0] j);
    @(negedge clk);
    jdo = j; ta = a; tbw = b; tna = na;
    @(negedge clk);
    ta = 1'b0; tbw = 1'b0; tna = 1'b0;
  endtask

  task automatic serve(input int delay, input logic [31:0] rd);
    int n;
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mem_req) begin
      n_vec++;
      n_err++;
      $display("FAIL serve_wait: got no mem_req expected mem_req within 20 cycles");
      return;
    end
    repeat (delay - 1) @(negedge clk);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = rd;
    @(negedge clk);
    bus.mem_ack = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_wait: got monitor_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic rd_at(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
    strobe(1'b0, 1'b0, 1'b1, '0);
    serve(1, d);
    wait_ready();
    check("MonDReg_read", mon, d);
  endtask

  task automatic wr_at(input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back('{we: 1'b1, addr: a, wdata: d});
    strobe(1'b0, 1'b1, 1'b0, mk_b(d));
    serve(1, 32'h0);
    wait_ready();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_MonDReg", mon, 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_error", 32'(err), 32'd0);
    reset = 1'b0;

    // Load address 0x12 with read, ack two cycles after request.
    exp_q.push_back('{we: 1'b0, addr: 8'h12, wdata: 32'h0});
    strobe(1'b1, 1'b0, 1'b0, mk_a(8'h12, 1'b1, 1'b0));
    check("ready_low_busy", 32'(ready), 32'd0);
    serve(2, 32'hCAFEF00D);
    wait_ready();
    check("MonDReg_load_read", mon, 32'hCAFEF00D);
    check("err_after_load", 32'(err), 32'd0);

    // Minimum latency: ready returns exactly 3 cycles after the strobe with a 1-cycle ack.
    exp_q.push_back('{we: 1'b0, addr: 8'h13, wdata: 32'h0});
    strobe(1'b0, 1'b0, 1'b1, '0);
    serve(1, 32'h13131313);
    check("ready_in_done", 32'(ready), 32'd0);
    @(negedge clk);
    check("ready_after_3", 32'(ready), 32'd1);
    check("MonDReg_incr_read", mon, 32'h13131313);

    // Address load without read, then write burst across the wrap.
    strobe(1'b1, 1'b0, 1'b0, mk_a(8'hFE, 1'b0, 1'b0));
    check("noread_req", 32'(bus.mem_req), 32'd0);
    check("noread_ready", 32'(ready), 32'd1);
    wr_at(8'hFE, 32'd1);
    wr_at(8'hFF, 32'd2);
    wr_at(8'h00, 32'd3);
    rd_at(8'h01, 32'hA5A5A5A5);

    // Busy collision: second strobe during REQ is dropped.
    exp_q.push_back('{we: 1'b0, addr: 8'h02, wdata: 32'h0});
    strobe(1'b0, 1'b0, 1'b1, '0);
    tna = 1'b1;
    @(negedge clk);
    tna = 1'b0;
    check("busy_err", 32'(err), 32'd1);
    check("busy_req_held", 32'(bus.mem_req), 32'd1);
    serve(1, 32'hDEADBEEF);
    wait_ready();
    check("busy_MonDReg", mon, 32'hDEADBEEF);
    rd_at(8'h03, 32'h00000303);

    // Clear error through ocimem_a with the clear flag.
    strobe(1'b1, 1'b0, 1'b0, mk_a(8'h40, 1'b0, 1'b1));
    check("err_cleared", 32'(err), 32'd0);

    // Simultaneous ocimem_a and ocimem_b: only the load happens.
    strobe(1'b1, 1'b1, 1'b0, mk_a(8'h80, 1'b0, 1'b0));
    check("simul_no_req", 32'(bus.mem_req), 32'd0);
    check("simul_err", 32'(err), 32'd1);
    rd_at(8'h80, 32'h80808080);

    // Stray ack while idle is ignored.
    @(negedge clk);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("stray_ack_MonDReg", mon, 32'h80808080);
    check("stray_ack_ready", 32'(ready), 32'd1);
    rd_at(8'h81, 32'h81818181);

    // Reset in the middle of a request.
    exp_q.push_back('{we: 1'b0, addr: 8'h82, wdata: 32'h0});
    strobe(1'b0, 1'b0, 1'b1, '0);
    check("pre_rst_req", 32'(bus.mem_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst_req", 32'(bus.mem_req), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_MonDReg", mon, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_at(8'h00, 32'h5A5A0000);

`ifdef DEBUG_MEM_TIMEOUT_EN
    begin
      int n;
      exp_q.push_back('{we: 1'b0, addr: 8'h01, wdata: 32'h0});
      strobe(1'b0, 1'b0, 1'b1, '0);
      n = 0;
      while (bus.mem_req && n < 400) begin
        n++;
        @(negedge clk);
      end
      check("timeout_cycles", 32'(n), 32'd255);
      check("timeout_err", 32'(err), 32'd1);
      wait_ready();
      check("timeout_MonDReg", mon, 32'h5A5A0000);
      rd_at(8'h01, 32'h01010101);
    end
`endif

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
